// File: rtl/moving_ave_pkg.sv
// Shared types for the MOVING_AVE frame sequencer.
// Frame FSM state encoding and default widths.
package moving_ave_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAMES_W   = 16;

    typedef enum logic [1:0] {
        FLUSH,
        WAIT_RDY,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/moving_ave_frame_ctrl.sv
// Frame sequencer in front of the MOVING_AVE datapath.
// Optional drain timeout: define MAVE_CTRL_TIMEOUT_EN.
module moving_ave_frame_ctrl
    import moving_ave_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = 256,
    parameter int WARMUP    = 128,
    parameter int FLUSH_CYC = 2,
    parameter int DRAIN_TMO = 1024
) (
    input  logic                CLK,
    input  logic                RESET_n,
    input  logic                ENABLE,
    output logic                ASI_READY,
    input  logic                ASI_VALID,
    input  logic [DATA_W-1:0]   ASI_DATA,
    output logic                AVE_RESET_n,
    input  logic                AVE_READY,
    output logic                AVE_VALID,
    output logic [DATA_W-1:0]   AVE_DATA,
    input  logic                AVE_OUT_VALID,
    input  logic [DATA_W-1:0]   AVE_OUT_DATA,
    input  logic                AVE_OUT_ERROR,
    output logic                ASO_VALID,
    output logic [DATA_W-1:0]   ASO_DATA,
    output logic                ASO_ERROR,
    output logic                ASO_SOP,
    output logic                ASO_EOP,
    output logic                STS_BUSY,
    output logic                STS_ERROR,
    output logic [FRAMES_W-1:0] STS_FRAMES
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int FL_W  = $clog2(FLUSH_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] WARM_IDX = CNT_W'(WARMUP);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [FL_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             out_act;
    logic             fwd;
    logic             done;
    logic             frame_done;
    logic             tmo_hit;
    logic             tmo_err;
    logic             stray;

    assign AVE_RESET_n = (state != FLUSH);
    assign AVE_DATA    = ASI_DATA;

    assign out_act = AVE_OUT_VALID && ((state == RUN) || (state == DRAIN));
    assign fwd     = out_act && (out_cnt >= WARM_IDX) && (out_cnt <= LAST_IDX);
    assign done    = (out_cnt == FULL_IDX)
                  || (AVE_OUT_VALID && (out_cnt == LAST_IDX));
    assign stray   = AVE_OUT_VALID && ((state == FLUSH) || (state == WAIT_RDY));

`ifdef MAVE_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(DRAIN_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TMO - 1);
    localparam logic [TMO_W-1:0] TMO_FULL = TMO_W'(DRAIN_TMO);

    logic [TMO_W-1:0] tmo_cnt;

    // Cycles spent in DRAIN; cleared whenever the FSM is elsewhere
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            tmo_cnt <= '0;
        end else if (state != DRAIN) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_FULL) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == DRAIN) && (tmo_cnt == TMO_LAST);
`else
    // Timeout disabled: DRAIN waits for the last word indefinitely
    assign tmo_hit = (DRAIN_TMO < 0);
`endif

    // Next-state and handshake gating
    always_comb begin
        state_nxt  = state;
        ASI_READY  = 1'b0;
        AVE_VALID  = 1'b0;
        frame_done = 1'b0;
        tmo_err    = 1'b0;
        unique case (state)
            FLUSH: begin
                if (flush_cnt == FL_LAST) state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (AVE_READY && ENABLE) state_nxt = RUN;
            end
            RUN: begin
                ASI_READY = AVE_READY;
                AVE_VALID = ASI_VALID && AVE_READY;
                if (AVE_VALID && (in_cnt == LAST_IDX)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (done) begin
                    state_nxt  = FLUSH;
                    frame_done = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = FLUSH;
                    tmo_err   = 1'b1;
                end
            end
            default: state_nxt = FLUSH;
        endcase
    end

    // State register and flush hold timer
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= FLUSH;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if ((state == FLUSH) && (state_nxt == FLUSH)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end else begin
                flush_cnt <= '0;
            end
        end
    end

    // Input beat and averager output word counters
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (state == FLUSH) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (AVE_VALID) in_cnt <= in_cnt + 1'b1;
            if (out_act && (out_cnt != FULL_IDX)) begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    // Registered downstream word with framing; zeroed when idle
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ASO_VALID <= 1'b0;
            ASO_DATA  <= '0;
            ASO_ERROR <= 1'b0;
            ASO_SOP   <= 1'b0;
            ASO_EOP   <= 1'b0;
        end else begin
            ASO_VALID <= fwd;
            ASO_DATA  <= fwd ? AVE_OUT_DATA : '0;
            ASO_ERROR <= fwd && AVE_OUT_ERROR;
            ASO_SOP   <= fwd && (out_cnt == WARM_IDX);
            ASO_EOP   <= fwd && (out_cnt == LAST_IDX);
        end
    end

    // Status: busy, sticky error, completed frame count
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            STS_BUSY   <= 1'b0;
            STS_ERROR  <= 1'b0;
            STS_FRAMES <= '0;
        end else begin
            STS_BUSY <= (state_nxt != WAIT_RDY);
            if ((AVE_OUT_VALID && AVE_OUT_ERROR) || stray || tmo_err) begin
                STS_ERROR <= 1'b1;
            end
            if (frame_done) STS_FRAMES <= STS_FRAMES + 1'b1;
        end
    end

endmodule

// File: tb/tb_moving_ave_frame_ctrl.sv
// Bench for moving_ave_frame_ctrl with a one-cycle averager stand-in.
// Scoreboard queue filled by the driver, drained by an output monitor.
module tb_moving_ave_frame_ctrl;

    localparam int FL = 256;
    localparam int WU = 128;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        ENABLE = 1'b0;
    logic        ASI_READY;
    logic        ASI_VALID = 1'b0;
    logic [15:0] ASI_DATA = 16'h0;
    logic        AVE_RESET_n;
    logic        AVE_READY = 1'b1;
    logic        AVE_VALID;
    logic [15:0] AVE_DATA;
    logic        AVE_OUT_VALID;
    logic [15:0] AVE_OUT_DATA;
    logic        AVE_OUT_ERROR;
    logic        ASO_VALID;
    logic [15:0] ASO_DATA;
    logic        ASO_ERROR;
    logic        ASO_SOP;
    logic        ASO_EOP;
    logic        STS_BUSY;
    logic        STS_ERROR;
    logic [15:0] STS_FRAMES;

    typedef struct {
        logic [15:0] d;
        logic        e;
        logic        s;
        logic        p;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   tests = 0;
    int   fails = 0;
    int   words = 0;
    logic err_en = 1'b0;
    logic stub_hold = 1'b0;
    int   stub_cnt;

    moving_ave_frame_ctrl #(
        .DATA_W(16), .FRAME_LEN(FL), .WARMUP(WU),
        .FLUSH_CYC(2), .DRAIN_TMO(1024)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n), .ENABLE(ENABLE),
        .ASI_READY(ASI_READY), .ASI_VALID(ASI_VALID), .ASI_DATA(ASI_DATA),
        .AVE_RESET_n(AVE_RESET_n), .AVE_READY(AVE_READY),
        .AVE_VALID(AVE_VALID), .AVE_DATA(AVE_DATA),
        .AVE_OUT_VALID(AVE_OUT_VALID), .AVE_OUT_DATA(AVE_OUT_DATA),
        .AVE_OUT_ERROR(AVE_OUT_ERROR),
        .ASO_VALID(ASO_VALID), .ASO_DATA(ASO_DATA), .ASO_ERROR(ASO_ERROR),
        .ASO_SOP(ASO_SOP), .ASO_EOP(ASO_EOP),
        .STS_BUSY(STS_BUSY), .STS_ERROR(STS_ERROR), .STS_FRAMES(STS_FRAMES)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int mode, input int k);
        case (mode)
            0:       return 16'h7FFF;
            1:       return 16'(k * 3 + 256);
            default: return 16'hA5A5 ^ 16'(k);
        endcase
    endfunction

    // Averager stand-in: echoes each accepted sample one cycle later
    always @(posedge CLK or negedge AVE_RESET_n) begin
        if (!AVE_RESET_n) begin
            AVE_OUT_VALID <= 1'b0;
            AVE_OUT_DATA  <= 16'h0;
            AVE_OUT_ERROR <= 1'b0;
            stub_cnt      <= 0;
        end else begin
            AVE_OUT_VALID <= AVE_VALID && !stub_hold;
            AVE_OUT_DATA  <= AVE_VALID ? AVE_DATA : 16'h0;
            AVE_OUT_ERROR <= AVE_VALID && err_en && (stub_cnt == 200);
            if (AVE_VALID) stub_cnt <= stub_cnt + 1;
        end
    end

    // Output monitor against the scoreboard
    always @(negedge CLK) begin
        if (ASO_VALID) begin
            words++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL aso_unexpected: got word %0h expected none",
                         ASO_DATA);
            end else begin
                ex = sb.pop_front();
                chk("aso_data", 32'(ASO_DATA), 32'(ex.d));
                chk("aso_error", 32'(ASO_ERROR), 32'(ex.e));
                chk("aso_sop", 32'(ASO_SOP), 32'(ex.s));
                chk("aso_eop", 32'(ASO_EOP), 32'(ex.p));
            end
        end else if (RESET_n) begin
            chk("aso_idle_zero",
                32'({ASO_DATA, ASO_ERROR, ASO_SOP, ASO_EOP}), 32'h0);
        end
    end

    int run = 0;
    int beats = 0;
    bit skip = 1'b1;
    bit bad = 1'b0;
    bit prev = 1'b0;

    // Flush gap length, input gating in flush, beats per frame
    always @(negedge CLK) begin
        if (!RESET_n) begin
            run = 0; skip = 1'b1; bad = 1'b0; beats = 0; prev = 1'b0;
        end else begin
            if (!AVE_RESET_n) begin
                if (prev) begin
                    chk("beats_per_frame", beats, FL);
                    beats = 0;
                end
                run++;
                if (ASI_READY) bad = 1'b1;
            end else begin
                if (run > 0) begin
                    if (!skip) begin
                        chk("flush_len", run, 2);
                        chk("flush_rdy_low", 32'(bad), 0);
                    end
                    run = 0; skip = 1'b0; bad = 1'b0;
                end
                if (AVE_VALID) beats++;
            end
            prev = AVE_RESET_n;
        end
    end

    task automatic stream(input int n, input int mode, input bit tog,
                          input bit stall, input bit push, input int en_drop);
        int k = 0;
        int cyc = 0;
        int ix;
        bit acc;
        logic [15:0] d;
        while (k < n && cyc < 20000) begin
            d = pat(mode, k);
            ix = k % FL;
            ASI_DATA  = d;
            ASI_VALID = tog ? cyc[0] : 1'b1;
            AVE_READY = !(stall && ((cyc % 5) == 2 || (cyc % 5) == 3));
            if (k == en_drop) ENABLE = 1'b0;
            @(negedge CLK);
            acc = ASI_VALID && ASI_READY;
            if (acc && push && ix >= WU) begin
                sb.push_back('{d, err_en && ix == 200, ix == WU, ix == FL - 1});
            end
            @(posedge CLK);
            #1;
            if (acc) k++;
            cyc++;
        end
        if (k < n) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got %0d beats expected %0d", k, n);
        end
        ASI_VALID = 1'b0;
        AVE_READY = 1'b1;
    endtask

    task automatic wait_frames(input int n);
        int c = 0;
        while (STS_FRAMES != 16'(n) && c < 3000) begin
            @(posedge CLK);
            #1;
            c++;
        end
        repeat (4) @(posedge CLK);
        #1;
        chk("sts_frames", 32'(STS_FRAMES), n);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic reset_checks();
        chk("rst_asi_ready", 32'(ASI_READY), 0);
        chk("rst_ave_reset_n", 32'(AVE_RESET_n), 0);
        chk("rst_ave_valid", 32'(AVE_VALID), 0);
        chk("rst_aso", 32'({ASO_VALID, ASO_DATA, ASO_ERROR, ASO_SOP, ASO_EOP}), 0);
        chk("rst_busy", 32'(STS_BUSY), 0);
        chk("rst_error", 32'(STS_ERROR), 0);
        chk("rst_frames", 32'(STS_FRAMES), 0);
    endtask

    task automatic apply_reset();
        RESET_n   = 1'b0;
        ASI_VALID = 1'b0;
        #2;
        reset_checks();
        repeat (2) @(posedge CLK);
        #1;
        RESET_n = 1'b1;
    endtask

    initial begin
        #1;
        apply_reset();
        ENABLE = 1'b1;

        // constant 0x7FFF frame
        words = 0;
        stream(256, 0, 1'b0, 1'b0, 1'b1, -1);
        wait_frames(1);
        chk("t1_words", words, 128);

        // back-to-back frames with valid held high
        ASI_VALID = 1'b1;
        stream(512, 1, 1'b0, 1'b0, 1'b1, -1);
        wait_frames(3);

        // 50% valid plus averager stalls
        stream(512, 2, 1'b1, 1'b1, 1'b1, -1);
        wait_frames(5);

        // enable dropped mid-frame
        apply_reset();
        ENABLE = 1'b1;
        stream(256, 1, 1'b0, 1'b0, 1'b1, 100);
        wait_frames(1);
        ASI_VALID = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        chk("t4_busy", 32'(STS_BUSY), 0);
        chk("t4_no_ready", 32'(ASI_READY), 0);
        chk("t4_frames", 32'(STS_FRAMES), 1);
        ASI_VALID = 1'b0;

        // error flagged on word 200, sticky across next frame
        ENABLE = 1'b1;
        err_en = 1'b1;
        stream(256, 2, 1'b0, 1'b0, 1'b1, -1);
        wait_frames(2);
        chk("t5_sts_error", 32'(STS_ERROR), 1);
        err_en = 1'b0;
        stream(256, 1, 1'b0, 1'b0, 1'b1, -1);
        wait_frames(3);
        chk("t5_sticky", 32'(STS_ERROR), 1);

        // reset mid-frame after 50 beats
        ASI_VALID = 1'b1;
        stream(50, 1, 1'b0, 1'b0, 1'b1, -1);
        ASI_VALID = 1'b1;
        apply_reset();
        ASI_VALID = 1'b0;
        chk("t6_sb_empty", sb.size(), 0);
        stream(256, 0, 1'b0, 1'b0, 1'b1, -1);
        wait_frames(1);
        chk("t6_error_clear", 32'(STS_ERROR), 0);

`ifdef MAVE_CTRL_TIMEOUT_EN
        begin
            int c = 0;
            stub_hold = 1'b1;
            stream(256, 1, 1'b0, 1'b0, 1'b0, -1);
            while (!STS_ERROR && c < 1200) begin
                @(posedge CLK);
                #1;
                c++;
            end
            chk("tmo_error", 32'(STS_ERROR), 1);
            chk("tmo_window", 32'(c >= 1020 && c <= 1030), 1);
            chk("tmo_frames", 32'(STS_FRAMES), 1);
            stub_hold = 1'b0;
            ENABLE = 1'b0;
            repeat (10) @(posedge CLK);
            #1;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
